// File: rtl/gba_dma_trigger.sv
// gba_dma_trigger: turns DMA timing events into per-channel pending bits and offers one start at a time
// Ports: fclk/reset (sync, active-high); dma_enable/dma_timing from DMACNT; GPU pulses hblank_trigger,
// vblank_trigger, videodma_start/stop; sound_fifo_req for ch1/ch2; start_valid/start_chan/start_ready
// handshake to the transfer engine; done_valid ends a transfer; pending, busy, ch3_disable status.
module gba_dma_trigger #(
  parameter int IMM_DELAY = 2
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic [3:0] dma_enable,
  input  logic [7:0] dma_timing,
  input  logic       hblank_trigger,
  input  logic       vblank_trigger,
  input  logic       videodma_start,
  input  logic       videodma_stop,
  input  logic [1:0] sound_fifo_req,
  output logic       start_valid,
  output logic [1:0] start_chan,
  input  logic       start_ready,
  input  logic       done_valid,
  output logic [3:0] pending,
  output logic       busy,
  output logic       ch3_disable
);
  localparam int CW = $clog2(IMM_DELAY + 1);
  logic [3:0] en_q, pending_q, pending_d, ev, cand, special_ev;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic start_valid_q, start_valid_d, busy_q, busy_d, ch3_dis_q, ch3_stop, accept;
  logic [1:0] start_chan_q, start_chan_d, pick;
  assign accept = start_valid_q & start_ready;
  // stop beats a same-cycle start for the video-capture channel
  assign special_ev = {videodma_start & ~videodma_stop, sound_fifo_req, 1'b0};
  assign ch3_stop = dma_enable[3] & (dma_timing[7:6] == 2'b11) & videodma_stop;
  always_comb begin
    ev = '0;
    pending_d = pending_q;
    for (int c = 0; c < 4; c++) begin
      // immediate channels fire on the cycle their delay counter reaches its last count
      ev[c] = dma_enable[c] & (dma_timing[2*c +: 2] == 2'b00 ? cnt_q[c] == CW'(1) :
                               dma_timing[2*c +: 2] == 2'b01 ? vblank_trigger :
                               dma_timing[2*c +: 2] == 2'b10 ? hblank_trigger : special_ev[c]);
      cnt_d[c] = !dma_enable[c] ? '0 :
                 (!en_q[c] && dma_timing[2*c +: 2] == 2'b00) ? CW'(IMM_DELAY) :
                 (cnt_q[c] != '0) ? cnt_q[c] - CW'(1) : '0;
      // a new event outranks a same-cycle accept so the extra request is not lost
      pending_d[c] = !dma_enable[c] ? 1'b0 :
                     (c == 3 && ch3_stop) ? 1'b0 :
                     ev[c] ? 1'b1 :
                     (accept && start_chan_q == 2'(c)) ? 1'b0 : pending_q[c];
    end
  end
  assign cand = pending_q & dma_enable;
  assign pick = cand[0] ? 2'd0 : cand[1] ? 2'd1 : cand[2] ? 2'd2 : 2'd3;
  always_comb begin
    start_valid_d = start_valid_q ? (!accept && dma_enable[start_chan_q]) : (!busy_q && |cand);
    start_chan_d = (!start_valid_q && !busy_q && |cand) ? pick : start_chan_q;
    busy_d = accept | (busy_q & ~done_valid);
  end
  always_ff @(posedge fclk) begin
    if (reset) begin
      en_q <= '0;
      pending_q <= '0;
      start_valid_q <= 1'b0;
      start_chan_q <= 2'd0;
      busy_q <= 1'b0;
      ch3_dis_q <= 1'b0;
      for (int c = 0; c < 4; c++) cnt_q[c] <= '0;
    end else begin
      en_q <= dma_enable;
      pending_q <= pending_d;
      start_valid_q <= start_valid_d;
      start_chan_q <= start_chan_d;
      busy_q <= busy_d;
      ch3_dis_q <= ch3_stop;
      for (int c = 0; c < 4; c++) cnt_q[c] <= cnt_d[c];
    end
  end
  assign start_valid = start_valid_q;
  assign start_chan = start_chan_q;
  assign pending = pending_q;
  assign busy = busy_q;
  assign ch3_disable = ch3_dis_q;
endmodule
